muldiv: RTL

MULDIV -- requirements
Module: muldiv

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_step.sv | 32 +++
 rtl/muldiv.sv | 126 ++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  localparam int unsigned ITERATIONS = 32;

  function automatic logic [31:0] mag32(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply (acc shifts right)
// or restoring shift-subtract divide (acc shifts left).
module muldiv_step (
  input  logic        is_div,
  input  logic [63:0] acc_i,
  input  logic [31:0] opnd_i,
  output logic [63:0] acc_o
);

  logic [32:0] sum;
  logic [32:0] rem;
  logic [33:0] diff;
  logic        unused_ok;

  // A non-negative trial difference always fits in 32 bits
  assign unused_ok = diff[32];

  always_comb begin
    sum  = {1'b0, acc_i[63:32]}
         + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
    rem  = acc_i[63:31];
    diff = {1'b0, rem} - {2'b00, opnd_i};
    acc_o = {sum, acc_i[31:1]};
    if (is_div) begin
      if (diff[33])
        acc_o = {rem[31:0], acc_i[30:0], 1'b0};
      else
        acc_o = {diff[31:0], acc_i[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv.sv
// Iterative 32-cycle multiply/divide unit owning the HI/LO registers.
module muldiv
  import muldiv_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_operand_a,
  input  logic [31:0] i_operand_b,
  input  logic        i_hi_we,
  input  logic        i_lo_we,
  input  logic [31:0] i_write_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] opnd_q;
  logic        is_div_q;
  logic        neg_q;
  logic        negr_q;
  logic        dz_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  logic        is_div_d;
  logic        sgn_d;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] acc_step;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    is_div_d = (i_op == OP_DIV) || (i_op == OP_DIVU);
    sgn_d    = (i_op == OP_MULT) || (i_op == OP_DIV);
    a_mag    = mag32(i_operand_a, sgn_d);
    b_mag    = mag32(i_operand_b, sgn_d);
  end

  muldiv_step u_step (
    .is_div (is_div_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_step)
  );

  // Magnitude result back to two's complement
  always_comb begin
    prod_fix = neg_q ? (~acc_q + 64'd1) : acc_q;
    quo_fix  = neg_q ? (~acc_q[31:0] + 32'd1)
                     : acc_q[31:0];
    rem_fix  = negr_q ? (~acc_q[63:32] + 32'd1)
                      : acc_q[63:32];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q  <= S_RUN;
            cnt_q    <= 5'd0;
            is_div_q <= is_div_d;
            neg_q    <= sgn_d & (i_operand_a[31] ^ i_operand_b[31]);
            negr_q   <= sgn_d & i_operand_a[31];
            dz_q     <= is_div_d && (i_operand_b == 32'd0);
            acc_q    <= {32'd0, is_div_d ? a_mag : b_mag};
            opnd_q   <= is_div_d ? b_mag : a_mag;
          end else begin
            if (i_hi_we) hi_q <= i_write_data;
            if (i_lo_we) lo_q <= i_write_data;
          end
        end
        S_RUN: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(ITERATIONS - 1))
            state_q <= S_FIX;
        end
        S_FIX: begin
          if (!is_div_q) begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end else if (dz_q) begin
            hi_q <= rem_fix;
            lo_q <= 32'hFFFF_FFFF;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
          done_q  <= 1'b1;
          cnt_q   <= 5'd0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy = (state_q != S_IDLE);
  assign o_done = done_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule
